// File: rtl/vg_beam_pkg.sv
// Shared types and widths for the vector-generator beam integrator.
package vg_beam_pkg;

    localparam int VG_COORD_W = 13;
    localparam int VG_SCALE_W = 8;
    localparam int VG_Z_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCALE,
        ST_SETUP,
        ST_DRAW,
        ST_DONE
    } vg_state_e;

endpackage

// File: rtl/vg_lin_scale.sv
// Linear scaler: s = (d * (256 - linscale)) >>> 8, floor rounding, wrapped to W bits.
module vg_lin_scale
    import vg_beam_pkg::*;
#(
    parameter int W = VG_COORD_W
) (
    input  logic [W-1:0]          d,
    input  logic [VG_SCALE_W-1:0] linscale,
    output logic [W-1:0]          s
);

    localparam int PW = W + VG_SCALE_W + 2;

    logic [VG_SCALE_W:0]  mult;
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] m_ext;
    logic signed [PW-1:0] prod;

    // Multiplier is 256 - linscale, so linscale = 0 means unity gain.
    always_comb begin
        mult  = {1'b1, {VG_SCALE_W{1'b0}}} - {1'b0, linscale};
        d_ext = {{(PW-W){d[W-1]}}, d};
        m_ext = {{(PW-VG_SCALE_W-1){1'b0}}, mult};
        prod  = d_ext * m_ext;
        s     = W'(prod >>> VG_SCALE_W);
    end

endmodule

// File: rtl/vg_beam_integrator.sv
// Beam integrator: scales a delta command, walks the beam with a Bresenham
// stepper and emits each lit position on a valid/ready point stream.
module vg_beam_integrator
    import vg_beam_pkg::*;
#(
    parameter int COORD_W = VG_COORD_W,
    parameter int Z_W     = VG_Z_W
) (
    input  logic                  clk_12MHz,
    input  logic                  reset,
    input  logic                  center,
    input  logic                  vec_start,
    input  logic [COORD_W-1:0]    dvx,
    input  logic [COORD_W-1:0]    dvy,
    input  logic [VG_SCALE_W-1:0] linscale,
    input  logic [Z_W-1:0]        z,
    output logic                  vec_busy,
    output logic                  vec_done,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [COORD_W-1:0]    pt_x,
    output logic [COORD_W-1:0]    pt_y,
    output logic [Z_W-1:0]        pt_z
);

    localparam int EW = COORD_W + 1;

    vg_state_e               state_q, state_d;
    logic [COORD_W-1:0]      bx_q, bx_d, by_q, by_d;
    logic [COORD_W-1:0]      dvx_q, dvx_d, dvy_q, dvy_d;
    logic [VG_SCALE_W-1:0]   ls_q, ls_d;
    logic [Z_W-1:0]          z_q, z_d;
    logic [COORD_W-1:0]      sdx_q, sdx_d, sdy_q, sdy_d;
    logic signed [EW-1:0]    err_q, err_d;
    logic [COORD_W-1:0]      cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic                    vec_busy_q, vec_busy_d;
    logic                    vec_done_q, vec_done_d;
    logic                    pt_valid_q, pt_valid_d;
    logic [COORD_W-1:0]      pt_x_q, pt_x_d, pt_y_q, pt_y_d;
    logic [Z_W-1:0]          pt_z_q, pt_z_d;

    logic [1:0][COORD_W-1:0] raw_vec;
    logic [1:0][COORD_W-1:0] scl_vec;

    assign raw_vec[0] = dvx_q;
    assign raw_vec[1] = dvy_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_scale
        vg_lin_scale #(.W(COORD_W)) u_scale (
            .d        (raw_vec[gi]),
            .linscale (ls_q),
            .s        (scl_vec[gi])
        );
    end

    logic [COORD_W-1:0]   ax, ay, n_len, minor_abs, inc_x, inc_y, step_x, step_y;
    logic                 major_x, minor_step, x_moves, y_moves;
    logic signed [EW-1:0] err_in, err_dec, err_step;

    // One Bresenham step from the current beam position; the initial error
    // term n/2 is injected while in SETUP so the first point is ready at DRAW entry.
    always_comb begin
        ax         = sdx_q[COORD_W-1] ? (~sdx_q + COORD_W'(1)) : sdx_q;
        ay         = sdy_q[COORD_W-1] ? (~sdy_q + COORD_W'(1)) : sdy_q;
        major_x    = (ax >= ay);
        n_len      = major_x ? ax : ay;
        minor_abs  = major_x ? ay : ax;
        inc_x      = sdx_q[COORD_W-1] ? {COORD_W{1'b1}} : COORD_W'(1);
        inc_y      = sdy_q[COORD_W-1] ? {COORD_W{1'b1}} : COORD_W'(1);
        err_in     = (state_q == ST_SETUP) ? $signed({1'b0, n_len >> 1}) : err_q;
        err_dec    = err_in - $signed({1'b0, minor_abs});
        minor_step = err_dec[EW-1];
        err_step   = minor_step ? (err_dec + $signed({1'b0, n_len})) : err_dec;
        x_moves    = major_x | minor_step;
        y_moves    = ~major_x | minor_step;
        step_x     = x_moves ? (bx_q + inc_x) : bx_q;
        step_y     = y_moves ? (by_q + inc_y) : by_q;
    end

    // Next-state logic for the command FSM, beam position and point stream.
    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dvx_d      = dvx_q;
        dvy_d      = dvy_q;
        ls_d       = ls_q;
        z_d        = z_q;
        sdx_d      = sdx_q;
        sdy_d      = sdy_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        vec_done_d = 1'b0;
        pt_valid_d = pt_valid_q;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;
        pt_z_d     = pt_z_q;

        if (center && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Center takes effect before a simultaneous start samples the beam.
                if (center) begin
                    bx_d = '0;
                    by_d = '0;
                end
                if (vec_start) begin
                    dvx_d   = dvx;
                    dvy_d   = dvy;
                    ls_d    = linscale;
                    z_d     = z;
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                sdx_d   = scl_vec[0];
                sdy_d   = scl_vec[1];
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (z_q == '0 || n_len == '0) begin
                    bx_d       = bx_q + sdx_q;
                    by_d       = by_q + sdy_q;
                    vec_done_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    bx_d       = step_x;
                    by_d       = step_y;
                    err_d      = err_step;
                    cnt_d      = n_len - COORD_W'(1);
                    pt_valid_d = 1'b1;
                    pt_x_d     = step_x;
                    pt_y_d     = step_y;
                    pt_z_d     = z_q;
                    state_d    = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (pt_valid_q && pt_ready) begin
                    if (cnt_q == '0) begin
                        pt_valid_d = 1'b0;
                        vec_done_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        bx_d   = step_x;
                        by_d   = step_y;
                        err_d  = err_step;
                        cnt_d  = cnt_q - COORD_W'(1);
                        pt_x_d = step_x;
                        pt_y_d = step_y;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (pend_q || center) begin
                    bx_d = '0;
                    by_d = '0;
                end
                pend_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vec_busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bx_q       <= '0;
            by_q       <= '0;
            dvx_q      <= '0;
            dvy_q      <= '0;
            ls_q       <= '0;
            z_q        <= '0;
            sdx_q      <= '0;
            sdy_q      <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            vec_busy_q <= 1'b0;
            vec_done_q <= 1'b0;
            pt_valid_q <= 1'b0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
            pt_z_q     <= '0;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dvx_q      <= dvx_d;
            dvy_q      <= dvy_d;
            ls_q       <= ls_d;
            z_q        <= z_d;
            sdx_q      <= sdx_d;
            sdy_q      <= sdy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            vec_busy_q <= vec_busy_d;
            vec_done_q <= vec_done_d;
            pt_valid_q <= pt_valid_d;
            pt_x_q     <= pt_x_d;
            pt_y_q     <= pt_y_d;
            pt_z_q     <= pt_z_d;
        end
    end

    assign vec_busy = vec_busy_q;
    assign vec_done = vec_done_q;
    assign pt_valid = pt_valid_q;
    assign pt_x     = pt_x_q;
    assign pt_y     = pt_y_q;
    assign pt_z     = pt_z_q;

endmodule

// File: tb/tb_vg_beam_integrator.sv
// Bench for vg_beam_integrator: table of directed vectors, hand sequences for
// reset/center corners, and random vectors against a closed-form line model.
module tb_vg_beam_integrator;

    localparam int BOUND = 10000;

    logic        clk = 1'b0;
    logic        reset, center, vec_start, pt_ready;
    logic [12:0] dvx, dvy;
    logic [7:0]  linscale;
    logic [2:0]  z;
    logic        vec_busy, vec_done, pt_valid;
    logic [12:0] pt_x, pt_y;
    logic [2:0]  pt_z;

    always #5 clk = ~clk;

    vg_beam_integrator dut (
        .clk_12MHz (clk),
        .reset     (reset),
        .center    (center),
        .vec_start (vec_start),
        .dvx       (dvx),
        .dvy       (dvy),
        .linscale  (linscale),
        .z         (z),
        .vec_busy  (vec_busy),
        .vec_done  (vec_done),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .pt_z      (pt_z)
    );

    typedef struct {
        int x;
        int y;
        int z;
    } pt_t;

    typedef struct {
        int dx; int dy; int ls; int zz;
        bit rnd; bit pre_c; int c_cyc;
        int np; int lx; int ly; int done_c;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int bx = 0;
    int by = 0;
    vec_t tbl[11];

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int wrap13(input int v);
        logic [12:0] t;
        t = v[12:0];
        return int'($signed(t));
    endfunction

    // floor(d * (256 - ls) / 256) using plain integer division
    function automatic int scale_ref(input int d, input int ls);
        int p;
        p = d * (256 - ls);
        if (p >= 0) return wrap13(p / 256);
        return wrap13(-((-p + 255) / 256));
    endfunction

    task automatic run_vector(input vec_t v, input bit check_exp);
        pt_t expq[$];
        pt_t got[$];
        pt_t p;
        int sdx, sdy, ax, ay, n, m, h, sgx, sgy, sx, sy;
        int first_v = -1;
        int done_c = -1;
        int held = 0;
        bit mx;
        bit stalled = 1'b0;
        bit busy_bad = 1'b0;
        if (v.pre_c) begin
            bx = 0;
            by = 0;
        end
        sx  = bx;
        sy  = by;
        sdx = scale_ref(v.dx, v.ls);
        sdy = scale_ref(v.dy, v.ls);
        ax  = (sdx < 0) ? -sdx : sdx;
        ay  = (sdy < 0) ? -sdy : sdy;
        mx  = (ax >= ay);
        n   = mx ? ax : ay;
        m   = mx ? ay : ax;
        h   = n / 2;
        sgx = (sdx < 0) ? -1 : 1;
        sgy = (sdy < 0) ? -1 : 1;
        // Minor offset after k major steps: smallest j keeping the error term non-negative
        if (v.zz != 0) begin
            for (int k = 1; k <= n; k++) begin
                int j;
                j   = (k * m - h + n - 1) / n;
                p.x = wrap13(sx + (mx ? sgx * k : sgx * j));
                p.y = wrap13(sy + (mx ? sgy * j : sgy * k));
                p.z = v.zz;
                expq.push_back(p);
            end
        end

        dvx       = 13'(v.dx);
        dvy       = 13'(v.dy);
        linscale  = 8'(v.ls);
        z         = 3'(v.zz);
        vec_start = 1'b1;
        center    = v.pre_c;
        pt_ready  = 1'b1;
        for (int cyc = 1; cyc <= BOUND; cyc++) begin
            @(posedge clk);
            #1;
            vec_start = 1'b0;
            center    = (cyc == v.c_cyc);
            if (stalled) chk("stall_hold", int'({pt_valid, pt_z, pt_x, pt_y}), held);
            if (!vec_busy) busy_bad = 1'b1;
            if (pt_valid && first_v < 0) first_v = cyc;
            if (vec_done) begin
                done_c = cyc;
                break;
            end
            pt_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pt_valid && pt_ready) begin
                p.x = int'($signed(pt_x));
                p.y = int'($signed(pt_y));
                p.z = int'(pt_z);
                got.push_back(p);
                stalled = 1'b0;
            end else if (pt_valid) begin
                stalled = 1'b1;
                held    = int'({1'b1, pt_z, pt_x, pt_y});
            end else begin
                stalled = 1'b0;
            end
        end
        center   = 1'b0;
        pt_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after", int'({vec_busy, vec_done, pt_valid}), 0);
        chk("done_seen", int'(done_c > 0), 1);
        chk("npts", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk("pt_x", got[i].x, expq[i].x);
            chk("pt_y", got[i].y, expq[i].y);
            chk("pt_z", got[i].z, expq[i].z);
        end
        chk("busy", int'(busy_bad), 0);
        chk("first_valid", first_v, (expq.size() > 0) ? 3 : -1);
        if (check_exp) begin
            chk("tbl_npts", got.size(), v.np);
            if (v.np > 0 && got.size() > 0) begin
                chk("tbl_last_x", got[got.size()-1].x, v.lx);
                chk("tbl_last_y", got[got.size()-1].y, v.ly);
            end
            if (v.done_c >= 0) chk("tbl_done_cyc", done_c, v.done_c);
        end
        bx = wrap13(sx + sdx);
        by = wrap13(sy + sdy);
        if (v.c_cyc >= 0) begin
            bx = 0;
            by = 0;
        end
        $display("vec dx=%0d dy=%0d ls=%0d z=%0d rnd=%0d pts=%0d done_cyc=%0d beam=(%0d,%0d)",
                 v.dx, v.dy, v.ls, v.zz, v.rnd, got.size(), done_c, bx, by);
    endtask

    initial begin
        vec_t r;
        //          dx    dy  ls  z rnd pre ccyc np   lx    ly  done
        tbl[0]  = '{10,    4,  0, 7, 0, 1, -1, 10,   10,   4, 13};
        tbl[1]  = '{-20,   0,128, 3, 0, 1, -1, 10,  -10,   0, 13};
        tbl[2]  = '{10,    4,  0, 7, 1, 1, -1, 10,   10,   4, -1};
        tbl[3]  = '{100, -50,  0, 0, 0, 1, -1,  0,    0,   0,  3};
        tbl[4]  = '{0,     0,  0, 7, 0, 0, -1,  0,    0,   0,  3};
        tbl[5]  = '{5,     1,  0, 1, 0, 0, -1,  5,  105, -49,  8};
        tbl[6]  = '{4095,  0,  0, 0, 0, 1, -1,  0,    0,   0,  3};
        tbl[7]  = '{1,     0,  0, 5, 0, 0, -1,  1,-4096,   0,  4};
        tbl[8]  = '{-1,   -3,128, 2, 0, 1, -1,  2,   -1,  -2,  5};
        tbl[9]  = '{6,     2,  0, 4, 0, 1,  5,  6,    6,   2,  9};
        tbl[10] = '{1,     0,  0, 1, 0, 0, -1,  1,    1,   0,  4};

        // Reset held with random inputs: outputs stay at zero, start ignored
        reset     = 1'b1;
        center    = 1'($urandom_range(0, 1));
        vec_start = 1'b1;
        dvx       = 13'($urandom);
        dvy       = 13'($urandom);
        linscale  = 8'($urandom);
        z         = 3'($urandom);
        pt_ready  = 1'($urandom_range(0, 1));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", int'({vec_busy, vec_done, pt_valid, pt_z, pt_x, pt_y}), 0);
            center    = 1'($urandom_range(0, 1));
            vec_start = 1'($urandom_range(0, 1));
            dvx       = 13'($urandom);
            dvy       = 13'($urandom);
            pt_ready  = 1'($urandom_range(0, 1));
        end
        reset     = 1'b0;
        center    = 1'b0;
        vec_start = 1'b0;
        pt_ready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("idle_after_reset", int'({vec_busy, vec_done, pt_valid}), 0);
        end
        bx = 0;
        by = 0;

        for (int i = 0; i < 11; i++) run_vector(tbl[i], 1'b1);

        // Reset in the middle of a draw discards the point and homes the beam
        dvx       = 13'd10;
        dvy       = 13'd4;
        linscale  = 8'd0;
        z         = 3'd7;
        vec_start = 1'b1;
        center    = 1'b1;
        pt_ready  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            vec_start = 1'b0;
            center    = 1'b0;
        end
        chk("mid_draw_valid", int'(pt_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_draw", int'({vec_busy, vec_done, pt_valid, pt_z, pt_x, pt_y}), 0);
        reset = 1'b0;
        bx = 0;
        by = 0;
        $display("reset mid-draw applied");
        r = '{2, 0, 0, 1, 0, 0, -1, 2, 2, 0, 5};
        run_vector(r, 1'b1);

        // Random vectors against the line model
        for (int i = 0; i < 12; i++) begin
            r.dx    = int'($urandom_range(0, 400)) - 200;
            r.dy    = int'($urandom_range(0, 400)) - 200;
            r.ls    = int'($urandom_range(0, 255));
            r.zz    = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
            r.rnd   = 1'($urandom_range(0, 1));
            r.pre_c = 1'($urandom_range(0, 1));
            r.c_cyc = -1;
            r.np    = 0;
            r.lx    = 0;
            r.ly    = 0;
            r.done_c = -1;
            run_vector(r, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
